// File: rtl/spi_flash_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | spi_flash_responder                                                        |
// | SPI mode-0 flash emulator: READ (0x03), JEDEC ID (0x9F), STATUS (0x05),    |
// | with one-byte prefetch buffer in front of a request/valid backing store.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4017,
    parameter int          MEM_AW   = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_busy,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    output logic              underrun
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        READ   = 3'd3,
        ID     = 3'd4,
        STATUS = 3'd5,
        IGNORE = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_sck_meta, r_sck_sync, r_sck_dly;
    logic r_mosi_meta, r_mosi_sync;
    logic r_cs_meta, r_cs_sync;

    logic [23:0]       r_shift_in;
    logic [4:0]        r_bit_cnt;
    logic [23:0]       r_addr;
    logic [7:0]        r_shift_out;
    logic [2:0]        r_out_cnt;
    logic [1:0]        r_id_idx;
    logic [7:0]        r_buf;
    logic              r_buf_valid;
    logic              r_mem_rd;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_outstanding;
    logic              r_discard;
    logic              r_underrun;

    logic        w_rise, w_fall;
    logic [23:0] w_shift_next;
    logic        w_cmd_done, w_addr_done;
    logic        w_tx, w_boundary, w_skip;
    logic        w_in_flight, w_issue;
    logic [7:0]  w_load_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_dly   <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_cs_meta   <= 1'b0;
            r_cs_sync   <= 1'b0;
        end else begin
            r_sck_meta  <= sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_dly   <= r_sck_sync;
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
            r_cs_meta   <= cs_n;
            r_cs_sync   <= r_cs_meta;
        end
    end

    // sck edges only count while the synchronized chip select is asserted
    assign w_rise       = ~r_cs_sync & r_sck_sync & ~r_sck_dly;
    assign w_fall       = ~r_cs_sync & ~r_sck_sync & r_sck_dly;
    assign w_shift_next = {r_shift_in[22:0], r_mosi_sync};
    assign w_cmd_done   = (r_state == CMD) && w_rise && (r_bit_cnt == 5'd7);
    assign w_addr_done  = (r_state == ADDR) && w_rise && (r_bit_cnt == 5'd23);
    assign w_tx         = (r_state == READ) || (r_state == ID) || (r_state == STATUS);
    assign w_boundary   = w_tx && w_fall && (r_out_cnt == 3'd0);
    assign w_skip       = w_boundary && (r_state == READ) && !r_buf_valid;
    assign w_in_flight  = r_mem_rd | r_outstanding;
    assign w_issue      = (r_state == READ) && !r_cs_sync && !r_buf_valid && !w_in_flight && !w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_cs_sync) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_next = CMD;
                CMD: begin
                    if (w_cmd_done) begin
                        case (w_shift_next[7:0])
                            8'h03:   w_state_next = ADDR;
                            8'h9F:   w_state_next = ID;
                            8'h05:   w_state_next = STATUS;
                            default: w_state_next = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (w_addr_done) begin
                        w_state_next = READ;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_load_byte = 8'hFF;
        case (r_state)
            READ: begin
                if (r_buf_valid) begin
                    w_load_byte = r_buf;
                end
            end
            ID: begin
                case (r_id_idx)
                    2'd0:    w_load_byte = JEDEC_ID[23:16];
                    2'd1:    w_load_byte = JEDEC_ID[15:8];
                    2'd2:    w_load_byte = JEDEC_ID[7:0];
                    default: w_load_byte = 8'hFF;
                endcase
            end
            STATUS:  w_load_byte = 8'h00;
            default: w_load_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_in    <= 24'd0;
            r_bit_cnt     <= 5'd0;
            r_addr        <= 24'd0;
            r_shift_out   <= 8'd0;
            r_out_cnt     <= 3'd0;
            r_id_idx      <= 2'd0;
            r_buf         <= 8'd0;
            r_buf_valid   <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            if (w_rise) begin
                r_shift_in <= w_shift_next;
                if (r_state == CMD) begin
                    r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
                end else if (r_state == ADDR) begin
                    r_bit_cnt <= (r_bit_cnt == 5'd23) ? 5'd0 : r_bit_cnt + 5'd1;
                end
            end

            if (w_addr_done) begin
                r_addr <= w_shift_next;
            end

            if (w_tx && w_fall) begin
                r_out_cnt <= r_out_cnt + 3'd1;
                if (r_out_cnt == 3'd0) begin
                    r_shift_out <= w_load_byte;
                    if ((r_state == ID) && (r_id_idx != 2'd3)) begin
                        r_id_idx <= r_id_idx + 2'd1;
                    end
                    // a missed byte still consumes its address
                    if (r_state == READ) begin
                        r_addr      <= r_addr + 24'd1;
                        r_buf_valid <= 1'b0;
                    end
                end else begin
                    r_shift_out <= {r_shift_out[6:0], 1'b0};
                end
            end

            if (w_skip) begin
                r_underrun <= 1'b1;
            end

            if (r_mem_rd && !mem_busy) begin
                r_mem_rd      <= 1'b0;
                r_outstanding <= 1'b1;
            end

            // stale fetches run to completion and are dropped on arrival
            if (r_outstanding && mem_valid) begin
                r_outstanding <= 1'b0;
                r_discard     <= 1'b0;
                if (!r_discard && !w_skip && !r_cs_sync && (r_state == READ)) begin
                    r_buf       <= mem_data;
                    r_buf_valid <= 1'b1;
                end
            end else if ((w_skip || r_cs_sync) && w_in_flight) begin
                r_discard <= 1'b1;
            end

            if (w_issue) begin
                r_mem_rd   <= 1'b1;
                r_mem_addr <= r_addr[MEM_AW-1:0];
            end

            if (r_cs_sync) begin
                r_bit_cnt   <= 5'd0;
                r_out_cnt   <= 3'd0;
                r_id_idx    <= 2'd0;
                r_shift_out <= 8'd0;
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign miso_oe  = w_tx & ~r_cs_sync;
    assign miso     = miso_oe & r_shift_out[7];
    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_spi_flash_responder                                                     |
// | Directed bench: SPI master, latency-3 memory model and expected-byte queue.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spi_flash_responder;

    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst, sck, mosi, cs_n;
    logic        miso, miso_oe, mem_rd, mem_busy, mem_valid, underrun;
    logic [22:0] mem_addr;
    logic [7:0]  mem_data;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [22:0] acc_q[$];
    logic        busy_force = 1'b0;
    logic        mon_en = 1'b0;
    int          viol = 0;
    int          lat_cnt = 0;
    logic [22:0] lat_addr = '0;

    spi_flash_responder #(.JEDEC_ID(24'hEF4017), .MEM_AW(23)) dut (
        .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_busy(mem_busy), .mem_data(mem_data), .mem_valid(mem_valid),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
    endfunction

    // backing store: accepts at the next rising edge, data returns 3 clk later
    initial begin
        mem_valid = 1'b0;
        mem_data  = 8'h00;
        mem_busy  = 1'b0;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = mem_byte(lat_addr);
                end
            end
            mem_busy = busy_force;
            if (mem_rd && !mem_busy && !rst) begin
                acc_q.push_back(mem_addr);
                lat_addr = mem_addr;
                lat_cnt  = 3;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && (miso_oe || mem_rd)) viol = viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        nclk(HALF);
        r   = miso;
        sck = 1'b1;
        nclk(HALF);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] rx;
        spi_byte(tx, rx);
    endtask

    task automatic send_read(input logic [23:0] a);
        send(8'h03);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic read_check(input int n, input string tag);
        logic [7:0] rx;
        logic [7:0] ex;
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rx);
            ex = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            check(tag, 32'(rx), 32'(ex));
        end
    endtask

    task automatic check_acc(input int idx, input logic [22:0] exp, input string tag);
        logic [31:0] obs;
        obs = (idx < acc_q.size()) ? 32'(acc_q[idx]) : 32'hDEAD_BEEF;
        check(tag, obs, 32'(exp));
    endtask

    task automatic cs_start;
        cs_n = 1'b0;
        nclk(10);
    endtask

    task automatic cs_end;
        nclk(10);
        cs_n = 1'b1;
        nclk(20);
    endtask

    initial begin
        logic b;
        rst  = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        nclk(10);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        nclk(10);

        // read of four bytes from 0x000010
        acc_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(mem_byte(23'h10 + 23'(i)));
        cs_start();
        send_read(24'h000010);
        check("read_oe", 32'(miso_oe), 32'd1);
        read_check(4, "read_data");
        check("read_underrun", 32'(underrun), 32'd0);
        cs_end();
        check("read_oe_off", 32'(miso_oe), 32'd0);
        for (int i = 0; i < 4; i++) check_acc(i, 23'h10 + 23'(i), "read_addr");

        // JEDEC ID followed by padding
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h17);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        cs_start();
        send(8'h9F);
        read_check(5, "id_data");
        cs_end();

        // address wrap at the top of the 24-bit space
        acc_q.delete();
        exp_q.push_back(mem_byte(23'h7FFFFE));
        exp_q.push_back(mem_byte(23'h7FFFFF));
        exp_q.push_back(mem_byte(23'h000000));
        cs_start();
        send_read(24'hFFFFFE);
        read_check(3, "wrap_data");
        cs_end();
        check_acc(0, 23'h7FFFFE, "wrap_addr0");
        check_acc(1, 23'h7FFFFF, "wrap_addr1");
        check_acc(2, 23'h000000, "wrap_addr2");

        // abort in the address phase, then in the data phase
        cs_start();
        send(8'h03);
        for (int i = 0; i < 12; i++) spi_bit(1'b0, b);
        cs_n = 1'b1;
        nclk(20);
        check("abort_addr_oe", 32'(miso_oe), 32'd0);
        check("abort_addr_rd", 32'(mem_rd), 32'd0);
        cs_start();
        send_read(24'h000040);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        cs_n = 1'b1;
        nclk(20);
        check("abort_data_oe", 32'(miso_oe), 32'd0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        cs_start();
        send(8'h05);
        read_check(2, "status_data");
        cs_end();
        check("abort_underrun", 32'(underrun), 32'd0);

        // unsupported command keeps the bus and memory quiet
        acc_q.delete();
        viol = 0;
        cs_start();
        mon_en = 1'b1;
        send(8'hAB);
        send(8'h00);
        send(8'h00);
        mon_en = 1'b0;
        cs_end();
        check("ignore_quiet", 32'(viol), 32'd0);
        check("ignore_no_fetch", 32'(acc_q.size()), 32'd0);

        // backing store stalled across six byte boundaries
        acc_q.delete();
        busy_force = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(mem_byte(23'h106));
        exp_q.push_back(mem_byte(23'h107));
        cs_start();
        send_read(24'h000100);
        read_check(5, "busy_ff");
        begin
            logic [7:0] rx;
            logic [7:0] ex;
            for (int i = 7; i >= 4; i--) begin
                spi_bit(1'b0, b);
                rx[i] = b;
            end
            busy_force = 1'b0;
            for (int i = 3; i >= 0; i--) begin
                spi_bit(1'b0, b);
                rx[i] = b;
            end
            ex = exp_q.pop_front();
            check("busy_ff6", 32'(rx), 32'(ex));
        end
        read_check(2, "busy_recover");
        check("busy_underrun", 32'(underrun), 32'd1);
        cs_end();
        check_acc(0, 23'h100, "busy_addr0");
        check_acc(1, 23'h106, "busy_addr1");
        check_acc(2, 23'h107, "busy_addr2");

        exp_q.push_back(8'h00);
        cs_start();
        send(8'h05);
        read_check(1, "sticky_status");
        cs_end();
        check("underrun_sticky", 32'(underrun), 32'd1);
        rst = 1'b1;
        nclk(3);
        check("underrun_cleared", 32'(underrun), 32'd0);
        rst = 1'b0;
        nclk(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter JEDEC_ID, 24'hEF4017, the three bytes returned by command 0x9F, MSB byte first.
REQ-002 SHALL have parameter MEM_AW, 23, the width of mem_addr.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port sck  input  1  SPI clock from the master, asynchronous to clk.
REQ-006 SHALL have port mosi  input  1  SPI data from the master, asynchronous to clk.
REQ-007 SHALL have port cs_n  input  1  SPI chip select, active low, asynchronous to clk.
REQ-008 SHALL have port miso  output  1  SPI data to the master.
REQ-009 SHALL have port miso_oe  output  1  drive enable for miso; the top level tri-states miso when this is 0.
REQ-010 SHALL have port mem_addr  output  MEM_AW  byte address for the backing-store read.
REQ-011 SHALL have port mem_rd  output  1  read request, held until accepted.
REQ-012 SHALL have port mem_busy  input  1  backing store busy; a request is accepted on a cycle where mem_rd=1 and mem_busy=0.
REQ-013 SHALL have port mem_data  input  8  read data, qualified by mem_valid.
REQ-014 SHALL have port mem_valid  input  1  one-cycle pulse carrying the data for the accepted request.
REQ-015 SHALL have port underrun  output  1  sticky flag: a data byte was not available in time.

Function
REQ-016 SHALL pass sck, mosi and cs_n through 2-flop synchronizers, then detect sck edges from the synchronized value and its one-cycle delay.
REQ-017 SHALL require sck high and low times of at least 16 clk; behaviour at faster sck is undefined.
REQ-018 SHALL operate in SPI mode 0: sample mosi on the detected sck rise, update miso on the detected sck fall, MSB first.
REQ-019 SHALL implement states IDLE, CMD, ADDR, READ, ID, STATUS and IGNORE.
REQ-020 SHALL move IDLE->CMD when synchronized cs_n goes low.
REQ-021 SHALL in CMD shift 8 bits, then decode: 0x03->ADDR; 0x9F->ID; 0x05->STATUS; any other value->IGNORE.
REQ-022 SHALL in ADDR shift 24 address bits; after the 24th rise, latch the address, issue the fetch (mem_addr = addr[MEM_AW-1:0]), and enter READ.
REQ-023 SHALL drive the first data bit on the sck fall that follows the 32nd rise; no dummy cycles.
REQ-024 SHALL in READ, once a fetched byte is loaded into the shift register, increment the address and request the next byte; at most one request is outstanding.
REQ-025 SHALL wrap the 24-bit address from 0xFFFFFF to 0x000000.
REQ-026 SHALL buffer one fetched byte; at each byte boundary (the fall after bit 0), load the buffered byte if present.
REQ-027 SHALL, if no byte is buffered at a byte boundary, shift out 0xFF for that byte, set underrun, and skip that address.
REQ-028 SHALL in ID shift out the three JEDEC_ID bytes, then 0xFF for all further bytes.
REQ-029 SHALL in STATUS shift out 0x00 repeatedly.
REQ-030 SHALL keep miso_oe=1 only in READ, ID and STATUS while cs_n is low; otherwise miso_oe=0 and miso=0.
REQ-031 SHALL on synchronized cs_n rising in any state return to IDLE within 1 clk and clear the bit counter and buffer.
REQ-032 SHALL, if a request is outstanding when cs_n rises, keep it pending until mem_valid and then discard that data; no new request is issued until then.
REQ-033 SHALL hold a requested mem_addr stable and keep mem_rd=1 until acceptance, and deassert mem_rd on the cycle after acceptance.
REQ-034 SHALL treat a sck edge while cs_n is high as no event.

Reset
REQ-035 SHALL, while rst=1, force state IDLE, miso=0, miso_oe=0, mem_rd=0, mem_addr=0, underrun=0, empty buffer and zeroed counters and synchronizers.
REQ-036 SHALL, when rst is asserted mid-transfer, abandon the transfer and drop any later mem_valid; the master restarts the transfer by toggling cs_n.

Verification
REQ-037 SHALL cover: cs_n low, 0x03 + address 0x000010, 4 bytes clocked, memory latency 3 clk -> miso returns mem[0x10..0x13], mem_addr takes values 0x10..0x13, underrun=0.
REQ-038 SHALL cover: 0x9F then 5 bytes clocked -> EF 40 17 FF FF.
REQ-039 SHALL cover: 0x03 + address 0xFFFFFE, 3 bytes clocked -> fetches from 0x7FFFFE, 0x7FFFFF, 0x000000 (wrap).
REQ-040 SHALL cover: mem_busy held high for 40 sck periods during READ -> affected bytes read 0xFF, underrun=1 and stays 1 until rst.
REQ-041 SHALL cover: cs_n raised after 12 address bits and after 3 data bits -> IDLE, miso_oe=0, then a new 0x05 command returns 0x00.
REQ-042 SHALL cover: command 0xAB -> miso_oe stays 0, no mem_rd for the rest of the cs_n low period.
